pipelined_pp_reducer: RTL and testbench
=======================================

Name: pipelined_pp_reducer

Overview:
- Parametrised, pipelined successor of the 16x32 combinational partial-product accumulator.
- Reduces N_OPS operands of WIDTH bits to a sum/carry pair using levels of 4:2 compressor rows, with one register stage per level.
- Optional final carry-propagate adder stage.
- Valid/ready handshake on both sides, full backpressure, flush, and a tag passed through unchanged.
- Sits between the partial-product generator and the multiplier result stage.

Parameters:
- WIDTH, 32: operand and result width; all arithmetic is mod 2^WIDTH.
- N_OPS, 16: operand count. Must be a power of 2 and >= 4. Compression levels LEVELS = log2(N_OPS) - 1.
- FINAL_ADD, 1: 1 adds a registered stage computing result_o = sum + carry; 0 ties result_o to 0.
- TAG_W, 4: width of the sideband tag carried alongside each operand set.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of every stage-valid bit.
- in_valid_i  in  1  operand set present.
- in_ready_o  out  1  block accepts the operand set this cycle.
- in_ops_i  in  N_OPS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- in_tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result present.
- out_ready_i  in  1  downstream accepts the result.
- sum_o  out  WIDTH  redundant sum vector.
- carry_o  out  WIDTH  redundant carry vector, already weighted (shifted left by 1, bit 0 = 0).
- result_o  out  WIDTH  sum_o + carry_o mod 2^WIDTH when FINAL_ADD = 1.
- tag_o  out  TAG_W  tag of the presented result.
- busy_o  out  1  OR of all stage-valid bits.

Behaviour:
- Reset: all stage-valid bits 0 and all data registers 0. Therefore out_valid_o = 0, sum_o = carry_o = result_o = 0, tag_o = 0, busy_o = 0. in_ready_o = 1 once rst deasserts.
- Stages: S = LEVELS + FINAL_ADD.
  - Stage k (k < LEVELS) holds N_OPS/2^(k+1) vectors. Stage 0 receives the compressed input.
  - Level k maps each group of 4 vectors to 2 vectors: s and (c << 1).
  - The last compression stage holds exactly 2 vectors, sum and carry.
- Latency: exactly S cycles from the accepting edge to out_valid_o = 1 when never stalled. Default configuration: 3 + 1 = 4.
- Throughput: one operand set per cycle when out_ready_i = 1.
- Handshake:
  - ready_k = !v_k || ready_(k+1), with ready_S = out_ready_i; in_ready_o = ready_0.
  - Stage k loads when ready_k is high.
  - Transfer occurs on valid && ready. A stalled stage holds data and tag stable.
  - Output data and tag must not change while out_valid_o = 1 and out_ready_i = 0.
- 4:2 compressor bit-slice, per bit i:
  - cout_i = maj(x0, x1, x2).
  - Second full adder takes x3, the first FA sum, and cin_i, where cin_i = cout_(i-1) and cin_0 = 0.
  - The cout from bit WIDTH-1 and carries out of bit WIDTH-1 are discarded.
- Invariant: sum_o + carry_o ≡ sum of all in_ops mod 2^WIDTH.
- Tag moves with its data through every stage.
- Flush:
  - flush_i = 1 clears every v_k at the edge. Data registers need not clear.
  - in_ready_o is forced to 0 during flush; simultaneous in_valid_i is dropped and not accepted.
  - out_valid_o drops to 0 the cycle after the edge.
- rst asserted mid-operation: immediate clear of all state, including data registers. In-flight sets are lost.
- Boundaries:
  - Full pipeline with out_ready_i = 0 gives in_ready_o = 0.
  - A bubble in any stage lets upstream advance into it.
  - When out_ready_i goes 0 then 1, no duplicate and no lost result.

Decomposition:
- Package pp_reducer_pkg:
  - function clog2-based LEVELS(n_ops).
  - function vectors_at_level(k).
  - typedef of the tag type.
  - localparam checks: N_OPS power of 2 and >= 4, else elaboration $error.
- Sub-module compressor_42_row (WIDTH param): combinational, 4 vectors in, s and shifted c out. Instantiated in a generate loop per level/group.
- Top contains the stage registers, valid/ready chain, and final adder.

Test Plan:
- Latency: single set, ops 0..15 = 1..16, out_ready_i = 1 -> out_valid_o at cycle 4 after accept; result_o = 136; sum_o + carry_o = 136; tag_o equals sent tag 0x5.
- Wrap: all 16 ops = 0xFFFF_FFFF -> result_o = 0xFFFF_FFF0.
- Streaming: 20 back-to-back random sets, out_ready_i = 1 -> 20 results in order, one per cycle, each matching the model sum mod 2^32.
- Backpressure: hold out_ready_i = 0 for 10 cycles while streaming -> in_ready_o falls after 4 accepts. Output stays stable, then drains in order with no loss or duplication.
- Flush: 3 sets in flight, flush_i pulse with in_valid_i = 1 -> no out_valid_o afterwards; the flushed-cycle input is not accepted; the next set completes normally.
- Parametric: N_OPS = 4, WIDTH = 8, FINAL_ADD = 0 -> latency 1, result_o = 0. Ops 0x80, 0x80, 0x01, 0x02 give sum_o + carry_o mod 256 = 0x03. Async rst mid-stream clears out_valid_o without a clock edge.

Source files
------------

// File: rtl/pp_reducer_pkg.sv
// Shared helpers for the pipelined partial-product reducer.
// Provides level/vector-count arithmetic, the operand-count sanity check,
// and the default sideband tag type.
package pp_reducer_pkg;

  localparam int TAG_W_DEF = 4;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // Number of 4:2 compression levels needed to bring n_ops vectors down to 2.
  function automatic int levels(input int n_ops);
    return $clog2(n_ops) - 1;
  endfunction

  // Vectors held in the register stage after compression level k.
  function automatic int vectors_at_level(input int n_ops, input int k);
    return n_ops >> (k + 1);
  endfunction

  // Operand count must be a power of two and at least 4.
  function automatic bit n_ops_ok(input int n_ops);
    return (n_ops >= 4) && ((n_ops & (n_ops - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipelined_pp_reducer_compressor_42_row.sv
// Combinational row of 4:2 compressors, one slice per bit.
// Ports: x0..x3 input vectors; s sum vector; c carry vector already
// weighted (shifted left by one, bit 0 = 0). Result is mod 2^WIDTH.
module compressor_42_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] cin;
  logic [WIDTH-2:0] cout;
  logic [WIDTH-2:0] c_low;

  // First full adder. Its carry out of the top bit would land at weight
  // 2^WIDTH, so only the lower WIDTH-1 carries are formed.
  assign s1   = x0 ^ x1 ^ x2;
  assign cout = (x0[WIDTH-2:0] & x1[WIDTH-2:0]) |
                (x0[WIDTH-2:0] & x2[WIDTH-2:0]) |
                (x1[WIDTH-2:0] & x2[WIDTH-2:0]);

  // Lateral carry: bit i receives cout of bit i-1; bit 0 receives 0.
  assign cin = {cout, 1'b0};

  // Second full adder: x3 + s1 + cin. Top-bit carry is dropped (mod 2^WIDTH).
  assign s     = x3 ^ s1 ^ cin;
  assign c_low = (x3[WIDTH-2:0] & s1[WIDTH-2:0]) |
                 (x3[WIDTH-2:0] & cin[WIDTH-2:0]) |
                 (s1[WIDTH-2:0] & cin[WIDTH-2:0]);
  assign c     = {c_low, 1'b0};

endmodule

// File: rtl/pipelined_pp_reducer.sv
// Pipelined reduction of N_OPS operands to a sum/carry pair through
// log2(N_OPS)-1 levels of registered 4:2 compressor rows, with an optional
// registered carry-propagate add. Tag travels with each set.
// Ports: clk/rst (async, active high); flush_i clears all stage valids;
// in_valid_i/in_ready_o/in_ops_i/in_tag_i upstream handshake;
// out_valid_o/out_ready_i/sum_o/carry_o/result_o/tag_o downstream;
// busy_o high while any stage holds a valid set.
module pipelined_pp_reducer
  import pp_reducer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_OPS     = 16,
  parameter int FINAL_ADD = 1,
  parameter int TAG_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N_OPS*WIDTH-1:0] in_ops_i,
  input  logic [TAG_W-1:0]       in_tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       sum_o,
  output logic [WIDTH-1:0]       carry_o,
  output logic [WIDTH-1:0]       result_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   busy_o
);

  localparam int LEVELS = levels(N_OPS);
  localparam int S      = LEVELS + ((FINAL_ADD != 0) ? 1 : 0);

  if (!n_ops_ok(N_OPS)) begin : g_bad_n_ops
    $error("pipelined_pp_reducer: N_OPS must be a power of 2 and >= 4");
  end

  logic [S:0]   rdy;
  logic [S-1:0] vld;

  // A stage can take new data when it is empty or its content moves on
  // this cycle; this ripples combinationally from the output back.
  always_comb begin
    rdy    = '0;
    rdy[S] = out_ready_i;
    for (int k = S - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  assign in_ready_o  = rdy[0] && !flush_i;
  assign out_valid_o = vld[S-1];
  assign busy_o      = |vld;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NV = vectors_at_level(N_OPS, k);

    logic [2*NV*WIDTH-1:0] src;
    logic [TAG_W-1:0]      src_tag;
    logic                  src_vld;
    logic [NV*WIDTH-1:0]   dat_d;
    logic [NV*WIDTH-1:0]   dat_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  v_q;

    if (k == 0) begin : g_src_in
      assign src     = in_ops_i;
      assign src_tag = in_tag_i;
      assign src_vld = in_valid_i;
    end else begin : g_src_prev
      assign src     = g_lvl[k-1].dat_q;
      assign src_tag = g_lvl[k-1].tag_q;
      assign src_vld = g_lvl[k-1].v_q;
    end

    // Group g compresses vectors 4g..4g+3 into slots 2g (sum) and 2g+1 (carry).
    for (genvar g = 0; g < NV / 2; g++) begin : g_grp
      compressor_42_row #(
        .WIDTH(WIDTH)
      ) u_row (
        .x0(src[(4*g+0)*WIDTH +: WIDTH]),
        .x1(src[(4*g+1)*WIDTH +: WIDTH]),
        .x2(src[(4*g+2)*WIDTH +: WIDTH]),
        .x3(src[(4*g+3)*WIDTH +: WIDTH]),
        .s (dat_d[(2*g+0)*WIDTH +: WIDTH]),
        .c (dat_d[(2*g+1)*WIDTH +: WIDTH])
      );
    end

    // Data loads on every ready cycle even behind a bubble; only the valid
    // bit decides whether that content means anything.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        dat_q <= '0;
        tag_q <= '0;
      end else begin
        if (flush_i) begin
          v_q <= 1'b0;
        end else if (rdy[k]) begin
          v_q <= src_vld;
        end
        if (rdy[k]) begin
          dat_q <= dat_d;
          tag_q <= src_tag;
        end
      end
    end

    assign vld[k] = v_q;
  end

  logic [WIDTH-1:0] red_sum;
  logic [WIDTH-1:0] red_carry;
  logic [TAG_W-1:0] red_tag;
  logic             red_vld;

  assign red_sum   = g_lvl[LEVELS-1].dat_q[0 +: WIDTH];
  assign red_carry = g_lvl[LEVELS-1].dat_q[WIDTH +: WIDTH];
  assign red_tag   = g_lvl[LEVELS-1].tag_q;
  assign red_vld   = g_lvl[LEVELS-1].v_q;

  if (FINAL_ADD != 0) begin : g_fin
    logic             v_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] res_q;
    logic [TAG_W-1:0] tag_q;

    // Redundant pair is kept alongside the resolved sum so all outputs
    // describe the same set.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q     <= 1'b0;
        sum_q   <= '0;
        carry_q <= '0;
        res_q   <= '0;
        tag_q   <= '0;
      end else begin
        if (flush_i) begin
          v_q <= 1'b0;
        end else if (rdy[LEVELS]) begin
          v_q <= red_vld;
        end
        if (rdy[LEVELS]) begin
          sum_q   <= red_sum;
          carry_q <= red_carry;
          res_q   <= red_sum + red_carry;
          tag_q   <= red_tag;
        end
      end
    end

    assign vld[LEVELS] = v_q;
    assign sum_o       = sum_q;
    assign carry_o     = carry_q;
    assign result_o    = res_q;
    assign tag_o       = tag_q;
  end else begin : g_no_fin
    assign sum_o    = red_sum;
    assign carry_o  = red_carry;
    assign result_o = '0;
    assign tag_o    = red_tag;
  end

endmodule

// File: tb/tb_pipelined_pp_reducer.sv
`timescale 1ns/1ps
module tb_pipelined_pp_reducer;
  import pp_reducer_pkg::*;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration DUT
  logic           rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [N*W-1:0] in_ops;
  tag_t           in_tag, tag;
  logic [W-1:0]   sum, carry, result;

  pipelined_pp_reducer #(.WIDTH(W), .N_OPS(N), .FINAL_ADD(1), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ops_i(in_ops), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .carry_o(carry), .result_o(result), .tag_o(tag), .busy_o(busy)
  );

  // Small configuration DUT: N_OPS=4, WIDTH=8, no final add
  logic        s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [31:0] s_ops;
  tag_t        s_in_tag, s_tag;
  logic [7:0]  s_sum, s_carry, s_result;

  pipelined_pp_reducer #(.WIDTH(8), .N_OPS(4), .FINAL_ADD(0), .TAG_W(TW)) u_small (
    .clk(clk), .rst(s_rst), .flush_i(s_flush),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_ops_i(s_ops), .in_tag_i(s_in_tag),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .sum_o(s_sum), .carry_o(s_carry), .result_o(s_result), .tag_o(s_tag), .busy_o(s_busy)
  );

  typedef struct packed {
    logic [W-1:0] res;
    tag_t         tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  bit   mon_en   = 1'b0;
  bit   was_stalled = 1'b0;
  exp_t held;

  // Scoreboard monitor: pops on every output transfer and checks that a
  // stalled output holds still.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (was_stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || result !== held.res || tag !== held.tag) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b result=%h tag=%h, required valid=1 result=%h tag=%h",
                   out_valid, result, tag, held.res, held.tag);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: result=%h tag=%h with nothing expected", result, tag);
        end else begin
          exp_t e;
          logic [W-1:0] sc;
          e  = sb.pop_front();
          sc = sum + carry;
          if (result !== e.res || sc !== e.res || tag !== e.tag) begin
            n_fail++;
            $display("FAIL scoreboard: result=%h sum+carry=%h tag=%h, required %h tag=%h",
                     result, sc, tag, e.res, e.tag);
          end
        end
      end else begin
        run_len = 0;
      end
      was_stalled = out_valid && !out_ready;
      held.res    = result;
      held.tag    = tag;
    end else begin
      was_stalled = 1'b0;
    end
  end

  function automatic logic [N*W-1:0] rand_ops();
    logic [N*W-1:0] o;
    for (int k = 0; k < N; k++) o[k*W +: W] = $urandom;
    return o;
  endfunction

  // Drive one set until accepted; optionally record its expected result.
  task automatic send(input logic [N*W-1:0] ops, input tag_t t, input bit expect_it);
    logic [W-1:0] acc;
    exp_t e;
    bit done;
    acc  = '0;
    done = 1'b0;
    for (int k = 0; k < N; k++) acc = acc + ops[k*W +: W];
    in_ops   = ops;
    in_tag   = t;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        if (expect_it) begin
          e.res = acc;
          e.tag = t;
          sb.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 for 50 cycles, required acceptance");
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ops = '0; in_tag = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_ops = '0; s_in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
    n_checks++;
    if (sum !== '0 || carry !== '0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_data: sum=%h carry=%h result=%h, required 0", sum, carry, result);
    end
    n_checks++;
    if (tag !== '0) begin
      n_fail++;
      $display("FAIL reset_tag: tag=%h, required 0", tag);
    end
    rst = 1'b0; s_rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b small=%b, required 1 1", in_ready, s_in_ready);
    end
  endtask

  task automatic test_latency();
    logic [N*W-1:0] ops;
    logic [W-1:0] sc;
    int lat;
    for (int k = 0; k < N; k++) ops[k*W +: W] = k + 1;
    out_ready = 1'b1;
    send(ops, 4'h5, 1'b1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sc = sum + carry;
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL latency: observed %0d cycles, required 4", lat);
    end
    n_checks++;
    if (result !== 32'd136 || sc !== 32'd136) begin
      n_fail++;
      $display("FAIL latency_sum: result=%0d sum+carry=%0d, required 136", result, sc);
    end
    n_checks++;
    if (tag !== 4'h5) begin
      n_fail++;
      $display("FAIL latency_tag: tag=%h, required 5", tag);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    logic [N*W-1:0] ops;
    int c;
    ops = '1;
    out_ready = 1'b1;
    send(ops, 4'h9, 1'b1);
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL wrap: valid=%b result=%h, required 1 fffffff0", out_valid, result);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_out;
    max_run = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(rand_ops(), tag_t'(i), 1'b1);
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (n_out - n0 !== 20) begin
      n_fail++;
      $display("FAIL stream_count: %0d results, required 20", n_out - n0);
    end
    n_checks++;
    if (max_run !== 20) begin
      n_fail++;
      $display("FAIL stream_rate: longest run %0d, required 20 consecutive", max_run);
    end
  endtask

  task automatic test_backpressure();
    int n0, acc;
    logic [W-1:0] sum_acc;
    exp_t e;
    bit take;
    n0  = n_out;
    acc = 0;
    out_ready = 1'b0;
    in_ops = rand_ops();
    in_tag = 4'h0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      take = in_ready;
      if (take) begin
        sum_acc = '0;
        for (int k = 0; k < N; k++) sum_acc = sum_acc + in_ops[k*W +: W];
        e.res = sum_acc;
        e.tag = in_tag;
        sb.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      if (take) begin
        in_ops = rand_ops();
        in_tag = tag_t'(acc);
      end
    end
    n_checks++;
    if (acc !== 4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: accepts=%0d in_ready=%b, required 4 0", acc, in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: out_valid=%b busy=%b, required 1 1", out_valid, busy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(rand_ops(), tag_t'(8 + i), 1'b1);
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (n_out - n0 !== 10) begin
      n_fail++;
      $display("FAIL bp_count: %0d results, required 10", n_out - n0);
    end
  endtask

  task automatic test_flush();
    int n0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(rand_ops(), tag_t'(i), 1'b0);
    flush = 1'b1;
    in_ops = rand_ops();
    in_tag = 4'hE;
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: in_ready=%b during flush, required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
    n0 = n_out;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (n_out !== n0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_quiet: %0d outputs busy=%b after flush, required 0 0", n_out - n0, busy);
    end
    send(rand_ops(), 4'hA, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (n_out - n0 !== 1) begin
      n_fail++;
      $display("FAIL flush_resume: %0d results, required 1", n_out - n0);
    end
  endtask

  task automatic test_small_config();
    logic [7:0] ssc;
    s_out_ready = 1'b1;
    s_ops = {8'h02, 8'h01, 8'h80, 8'h80};
    s_in_tag = 4'h3;
    s_in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL small_ready: in_ready=%b, required 1", s_in_ready);
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    ssc = s_sum + s_carry;
    n_checks++;
    if (s_out_valid !== 1'b1 || s_tag !== 4'h3) begin
      n_fail++;
      $display("FAIL small_latency: valid=%b tag=%h one cycle after accept, required 1 3", s_out_valid, s_tag);
    end
    n_checks++;
    if (ssc !== 8'h03 || s_result !== 8'h00) begin
      n_fail++;
      $display("FAIL small_sum: sum+carry=%h result=%h, required 03 00", ssc, s_result);
    end
    // Stall a new set at the output, then reset between clock edges.
    s_out_ready = 1'b0;
    s_ops = 32'h1122_3344;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (s_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL small_stream: valid=%b, required 1", s_out_valid);
    end
    #2;
    s_rst = 1'b1;
    #1;
    n_checks++;
    if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_sum !== 8'h00 || s_carry !== 8'h00 || s_tag !== 4'h0) begin
      n_fail++;
      $display("FAIL small_async_rst: valid=%b busy=%b sum=%h carry=%h tag=%h, required all 0",
               s_out_valid, s_busy, s_sum, s_carry, s_tag);
    end
    #1;
    s_rst = 1'b0;
    s_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_latency();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
